// File: rtl/mem_bus_arbiter_pkg.sv
// Configuration constants and shared types for the N-master to 1-slave memory bus arbiter.
package mem_bus_arbiter_pkg;

    localparam string RV_MEM_ARB_MODE    = "RR";
    localparam int    RV_MEM_ARB_MASTERS = 2;

    typedef enum logic {
        IDLE   = 1'b0,
        LOCKED = 1'b1
    } ArbState;

    // Index width that stays at least one bit wide for tiny configurations.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mem_bus_arbiter_rr_select.sv
// Wrap-around priority search: first requester at or after ptr wins, as one-hot and as an index.
module arb_rr_select
    import mem_bus_arbiter_pkg::*;
#(
    parameter int NUM_MASTERS = RV_MEM_ARB_MASTERS,
    parameter int IDX_W       = idx_width(NUM_MASTERS)
) (
    input  logic [NUM_MASTERS-1:0] req,
    input  logic [IDX_W-1:0]       ptr,
    output logic [NUM_MASTERS-1:0] grant,
    output logic [IDX_W-1:0]       idx,
    output logic                   found
);

    int               pos;
    logic [IDX_W-1:0] cand;

    always_comb begin
        grant = '0;
        idx   = '0;
        found = 1'b0;
        pos   = 0;
        cand  = '0;
        for (int k = 0; k < NUM_MASTERS; k++) begin
            // ptr is always below NUM_MASTERS, so a single subtraction wraps the search.
            pos = int'(ptr) + k;
            if (pos >= NUM_MASTERS) pos = pos - NUM_MASTERS;
            cand = IDX_W'(pos);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                idx         = cand;
            end
        end
    end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Per-transaction arbiter sharing one memory slave port among NUM_MASTERS requesters;
// the grant is locked to its owner while the slave stalls.
module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int    NUM_MASTERS = RV_MEM_ARB_MASTERS,
    parameter int    ADDR_WIDTH  = 32,
    parameter int    DATA_WIDTH  = 32,
    parameter string ARB_MODE    = RV_MEM_ARB_MODE
) (
    input  logic                                       i_clock,
    input  logic                                       i_reset,
    input  logic [NUM_MASTERS-1:0][ADDR_WIDTH-1:0]     i_m_addr,
    input  logic [NUM_MASTERS-1:0]                     i_m_re,
    input  logic [NUM_MASTERS-1:0]                     i_m_we,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH/8-1:0]   i_m_wb,
    input  logic [NUM_MASTERS-1:0][DATA_WIDTH-1:0]     i_m_wdata,
    output logic [DATA_WIDTH-1:0]                      o_m_rdata,
    output logic [NUM_MASTERS-1:0]                     o_m_busy,
    output logic [ADDR_WIDTH-1:0]                      o_s_addr,
    output logic                                       o_s_re,
    output logic                                       o_s_we,
    output logic [DATA_WIDTH/8-1:0]                    o_s_wb,
    output logic [DATA_WIDTH-1:0]                      o_s_wdata,
    input  logic [DATA_WIDTH-1:0]                      i_s_rdata,
    input  logic                                       i_s_busy,
    output logic [NUM_MASTERS-1:0]                     o_grant
);

    localparam int               IDX_W = idx_width(NUM_MASTERS);
    localparam bit               FIXED = (ARB_MODE == "FIXED");
    localparam logic [IDX_W-1:0] LAST  = IDX_W'(NUM_MASTERS - 1);

    ArbState                state, state_nxt;
    logic [IDX_W-1:0]       owner, owner_nxt;
    logic [IDX_W-1:0]       ptr, ptr_nxt, sel_ptr;
    logic [NUM_MASTERS-1:0] req, win_grant;
    logic [IDX_W-1:0]       win_idx, sel_idx;
    logic                   win_found, active, complete, abort;

    assign req       = i_m_re | i_m_we;
    assign sel_ptr   = FIXED ? '0 : ptr;
    assign o_m_rdata = i_s_rdata;

    arb_rr_select #(
        .NUM_MASTERS (NUM_MASTERS),
        .IDX_W       (IDX_W)
    ) u_select (
        .req   (req),
        .ptr   (sel_ptr),
        .grant (win_grant),
        .idx   (win_idx),
        .found (win_found)
    );

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state <= IDLE;
            owner <= '0;
            ptr   <= '0;
        end else begin
            state <= state_nxt;
            owner <= owner_nxt;
            ptr   <= ptr_nxt;
        end
    end

    // Slave-side outputs depend only on state and requests; i_s_busy feeds just
    // the next-state logic and the master stall flags.
    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        ptr_nxt   = ptr;
        o_grant   = '0;
        o_s_addr  = '0;
        o_s_re    = 1'b0;
        o_s_we    = 1'b0;
        o_s_wb    = '0;
        o_s_wdata = '0;

        sel_idx  = (state == LOCKED) ? owner : win_idx;
        active   = !i_reset && ((state == LOCKED) || win_found);
        complete = active && req[sel_idx] && !i_s_busy;
        abort    = !i_reset && (state == LOCKED) && !req[owner];

        if (active) begin
            if (state == LOCKED) o_grant[owner] = 1'b1;
            else                 o_grant        = win_grant;
            o_s_addr  = i_m_addr[sel_idx];
            o_s_re    = i_m_re[sel_idx];
            o_s_we    = i_m_we[sel_idx];
            o_s_wb    = i_m_wb[sel_idx];
            o_s_wdata = i_m_wdata[sel_idx];
        end

        o_m_busy = req;
        if (complete) o_m_busy[sel_idx] = 1'b0;

        case (state)
            IDLE: begin
                if (active && i_s_busy) begin
                    state_nxt = LOCKED;
                    owner_nxt = win_idx;
                end
            end
            LOCKED: begin
                if (complete || abort) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase

        if ((complete || abort) && !FIXED)
            ptr_nxt = (sel_idx == LAST) ? '0 : sel_idx + 1'b1;
    end

endmodule
